// File: rtl/laser_pkg.sv
// Shared constants and state encoding for the laser packet transmit path.
package laser_pkg;

    localparam int         PKT_WORDS_DEF      = 256;
    localparam int         TIMEOUT_CYCLES_DEF = 400;
    localparam int         MAX_RETRY_DEF      = 3;
    localparam logic [7:0] ACK_BYTE_DEF       = 8'h11;
    localparam int         WORD_W             = 16;
    localparam int         BYTE_W             = 8;

    typedef enum logic [2:0] {IDLE, SEND, WAIT_ACK} ctrl_state_t;

endpackage

// File: rtl/laser_pkt_tx_ctrl_if.sv
// Byte-pair link between the packet controller and the dual-laser transmitter.
interface laser_pkt_tx_ctrl_if;
    import laser_pkg::*;

    // Handshake: while tx_en/tx_ready are high the pair on tx_data1/tx_data2 is
    // held stable; tx_done is a one-cycle strobe ending that pair, and the next
    // pair is presented on the following cycle with no idle gap.
    logic              tx_en;
    logic              tx_ready;
    logic [BYTE_W-1:0] tx_data1;
    logic [BYTE_W-1:0] tx_data2;
    logic              tx_done;

    modport master (output tx_en, output tx_ready, output tx_data1, output tx_data2,
                    input tx_done);
    modport slave  (input tx_en, input tx_ready, input tx_data1, input tx_data2,
                    output tx_done);

endinterface

// File: rtl/laser_pkt_buffer.sv
// One-packet word buffer: synchronous write at wr_ptr, combinational read.
module laser_pkt_buffer
    import laser_pkg::*;
#(
    parameter int PKT_WORDS = PKT_WORDS_DEF,
    localparam int PW = $clog2(PKT_WORDS) + 1,
    localparam int AW = $clog2(PKT_WORDS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              clr,
    input  logic [AW-1:0]     rd_addr,
    output logic [WORD_W-1:0] rd_data,
    output logic [PW-1:0]     wr_ptr,
    output logic              wr_full
);

    logic [WORD_W-1:0] mem [PKT_WORDS];
    logic              do_write;

    assign wr_full  = (wr_ptr == PW'(PKT_WORDS));
    assign do_write = wr_en && !wr_full;
    assign rd_data  = mem[rd_addr];

    always_ff @(posedge clock) begin
        if (do_write) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Clear wins over a same-cycle write so abort always empties the packet.
    always_ff @(posedge clock) begin
        if (reset || clr) begin
            wr_ptr <= '0;
        end else if (do_write) begin
            wr_ptr <= wr_ptr + PW'(1);
        end
    end

endmodule

// File: rtl/laser_pkt_tx_ctrl.sv
// Packet sequencer: streams buffered byte pairs to the transmitter, waits for ACK, retries.
module laser_pkt_tx_ctrl
    import laser_pkg::*;
#(
    parameter int         PKT_WORDS      = PKT_WORDS_DEF,
    parameter int         TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int         MAX_RETRY      = MAX_RETRY_DEF,
    parameter logic [7:0] ACK_BYTE       = ACK_BYTE_DEF,
    localparam int PW = $clog2(PKT_WORDS) + 1,
    localparam int AW = $clog2(PKT_WORDS),
    localparam int RW = $clog2(MAX_RETRY + 1),
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [WORD_W-1:0]    wr_data,
    input  logic                 pkt_go,
    input  logic                 abort,
    input  logic                 rx_valid,
    input  logic [BYTE_W-1:0]    rx_byte,
    laser_pkt_tx_ctrl_if.master  tx,
    output logic                 busy,
    output logic                 wr_full,
    output logic                 pkt_done,
    output logic                 pkt_fail,
    output logic [RW-1:0]        retry_count,
    output ctrl_state_t          state_dbg,
    output logic [PW-1:0]        wr_ptr_dbg
);

    ctrl_state_t       state;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [TW-1:0]     timer;
    logic [WORD_W-1:0] rd_data;
    logic              buf_wr;
    logic              buf_clr;
    logic              ack_hit;
    logic              retry_hit;
    logic              retry_last;
    logic              len_nz;

    assign ack_hit    = rx_valid && (rx_byte == ACK_BYTE);
    assign retry_hit  = (rx_valid && (rx_byte != ACK_BYTE)) || (timer == TW'(TIMEOUT_CYCLES - 1));
    assign retry_last = (retry_count == RW'(MAX_RETRY));
    assign buf_wr     = (state == IDLE) && wr_en;
    // A write landing with pkt_go counts toward the packet length.
    assign len_nz     = (wr_ptr != '0) || (wr_en && !wr_full);
    assign buf_clr    = abort ||
                        ((state == WAIT_ACK) && (ack_hit || (retry_hit && retry_last)));

    laser_pkt_buffer #(.PKT_WORDS(PKT_WORDS)) u_buf (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (buf_wr),
        .wr_data (wr_data),
        .clr     (buf_clr),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (rd_data),
        .wr_ptr  (wr_ptr),
        .wr_full (wr_full)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            rd_ptr      <= '0;
            timer       <= '0;
            retry_count <= '0;
            pkt_done    <= 1'b0;
            pkt_fail    <= 1'b0;
        end else begin
            pkt_done <= 1'b0;
            pkt_fail <= 1'b0;
            if (abort) begin
                state       <= IDLE;
                rd_ptr      <= '0;
                timer       <= '0;
                retry_count <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (pkt_go && len_nz) begin
                            rd_ptr      <= '0;
                            retry_count <= '0;
                            state       <= SEND;
                        end
                    end
                    SEND: begin
                        if (tx.tx_done) begin
                            if (rd_ptr == wr_ptr - PW'(1)) begin
                                timer <= '0;
                                state <= WAIT_ACK;
                            end else begin
                                rd_ptr <= rd_ptr + PW'(1);
                            end
                        end
                    end
                    WAIT_ACK: begin
                        timer <= timer + TW'(1);
                        if (ack_hit) begin
                            pkt_done <= 1'b1;
                            state    <= IDLE;
                        end else if (retry_hit) begin
                            if (retry_last) begin
                                pkt_fail <= 1'b1;
                                state    <= IDLE;
                            end else begin
                                retry_count <= retry_count + RW'(1);
                                rd_ptr      <= '0;
                                state       <= SEND;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Data is gated by SEND so every output reads 0 out of reset.
    assign tx.tx_en    = (state == SEND);
    assign tx.tx_ready = (state == SEND);
    assign tx.tx_data1 = (state == SEND) ? rd_data[7:0]  : '0;
    assign tx.tx_data2 = (state == SEND) ? rd_data[15:8] : '0;
    assign busy        = (state != IDLE);
    assign state_dbg   = state;
    assign wr_ptr_dbg  = wr_ptr;

endmodule

// File: tb/tb_laser_pkt_tx_ctrl.sv
// Directed bench for laser_pkt_tx_ctrl: ACK, timeout retries, NAK, full buffer, abort/reset.
module tb_laser_pkt_tx_ctrl;
    import laser_pkg::*;

    logic        clock;
    logic        reset;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        pkt_go;
    logic        abort;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        busy;
    logic        wr_full;
    logic        pkt_done;
    logic        pkt_fail;
    logic [1:0]  retry_count;
    ctrl_state_t state_dbg;
    logic [8:0]  wr_ptr_dbg;

    laser_pkt_tx_ctrl_if tx_if ();

    laser_pkt_tx_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .pkt_go      (pkt_go),
        .abort       (abort),
        .rx_valid    (rx_valid),
        .rx_byte     (rx_byte),
        .tx          (tx_if),
        .busy        (busy),
        .wr_full     (wr_full),
        .pkt_done    (pkt_done),
        .pkt_fail    (pkt_fail),
        .retry_count (retry_count),
        .state_dbg   (state_dbg),
        .wr_ptr_dbg  (wr_ptr_dbg)
    );

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int fail_cnt = 0;
    int en_cnt = 0;
    int stab_bad = 0;
    logic [15:0] cap_q[$];
    logic [15:0] exp_q[$];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(negedge clock) begin
        if (pkt_done === 1'b1) done_cnt++;
        if (pkt_fail === 1'b1) fail_cnt++;
        if (tx_if.tx_en === 1'b1) en_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset = 1'b1;
        wr_en = 1'b0; wr_data = '0; pkt_go = 1'b0; abort = 1'b0;
        rx_valid = 1'b0; rx_byte = '0; tx_if.tx_done = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic write_word(input logic [15:0] w);
        wr_en = 1'b1;
        wr_data = w;
        @(negedge clock);
        wr_en = 1'b0;
    endtask

    task automatic write_three();
        write_word(16'hA1B2);
        write_word(16'hC3D4);
        write_word(16'hE5F6);
    endtask

    task automatic go_pkt();
        pkt_go = 1'b1;
        @(negedge clock);
        pkt_go = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte = b;
        @(negedge clock);
        rx_valid = 1'b0;
    endtask

    // Transmitter model: holds each pair for `period` cycles, strobing tx_done on the last.
    task automatic run_pass(input int n, input int period, input int abort_at);
        logic [15:0] cur;
        if (tx_if.tx_en !== 1'b1) begin
            total++; bad++;
            $display("FAIL pass_start tx_en=%b required 1", tx_if.tx_en);
            return;
        end
        for (int i = 0; i < n; i++) begin
            cur = {tx_if.tx_data2, tx_if.tx_data1};
            for (int c = 1; c < period; c++) begin
                @(negedge clock);
                if (tx_if.tx_en !== 1'b1 || tx_if.tx_ready !== 1'b1 ||
                    {tx_if.tx_data2, tx_if.tx_data1} !== cur) stab_bad++;
            end
            cap_q.push_back(cur);
            tx_if.tx_done = 1'b1;
            if (i == abort_at) abort = 1'b1;
            @(negedge clock);
            tx_if.tx_done = 1'b0;
            abort = 1'b0;
            if (i == abort_at) return;
        end
    endtask

    task automatic check_caps(input string name);
        total++;
        if (cap_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL %s count got=%0d required=%0d", name, cap_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                total++;
                if (cap_q[i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL %s pair%0d got=%h required=%h", name, i, cap_q[i], exp_q[i]);
                end
            end
        end
        total++;
        if (stab_bad != 0) begin
            bad++;
            $display("FAIL %s stability got=%0d glitches required=0", name, stab_bad);
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({busy, tx_if.tx_en, tx_if.tx_ready, wr_full, pkt_done, pkt_fail} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b required=000000",
                     {busy, tx_if.tx_en, tx_if.tx_ready, wr_full, pkt_done, pkt_fail});
        end
        total++;
        if ({tx_if.tx_data2, tx_if.tx_data1} !== 16'h0000 || retry_count !== 2'd0 ||
            wr_ptr_dbg !== 9'd0 || state_dbg !== IDLE) begin
            bad++;
            $display("FAIL reset_values data=%h retry=%0d wr_ptr=%0d state=%0d required all 0",
                     {tx_if.tx_data2, tx_if.tx_data1}, retry_count, wr_ptr_dbg, state_dbg);
        end
    endtask

    task automatic test_single_ack();
        do_reset();
        write_three();
        exp_q = {16'hA1B2, 16'hC3D4, 16'hE5F6};
        cap_q = {};
        stab_bad = 0;
        done_cnt = 0;
        go_pkt();
        total++;
        if (tx_if.tx_en !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL go_latency tx_en=%b busy=%b required 1 1", tx_if.tx_en, busy);
        end
        run_pass(3, 11, -1);
        check_caps("ack_pass");
        repeat (4) @(negedge clock);
        send_rx(8'h11);
        total++;
        if (pkt_done !== 1'b1 || busy !== 1'b0 || retry_count !== 2'd0) begin
            bad++;
            $display("FAIL ack_done pkt_done=%b busy=%b retry=%0d required 1 0 0",
                     pkt_done, busy, retry_count);
        end
        repeat (3) @(negedge clock);
        total++;
        if (done_cnt != 1 || pkt_done !== 1'b0) begin
            bad++;
            $display("FAIL ack_pulse count=%0d now=%b required 1 0", done_cnt, pkt_done);
        end
    endtask

    task automatic test_retry_timeout();
        int cnt;
        do_reset();
        write_three();
        exp_q = {};
        cap_q = {};
        stab_bad = 0;
        done_cnt = 0;
        fail_cnt = 0;
        go_pkt();
        for (int p = 0; p < 4; p++) begin
            exp_q.push_back(16'hA1B2);
            exp_q.push_back(16'hC3D4);
            exp_q.push_back(16'hE5F6);
            total++;
            if (retry_count !== 2'(p)) begin
                bad++;
                $display("FAIL retry_count_pass%0d got=%0d required=%0d", p, retry_count, p);
            end
            run_pass(3, 11, -1);
            cnt = 0;
            while (busy === 1'b1 && tx_if.tx_en === 1'b0 && cnt < 1000) begin
                cnt++;
                @(negedge clock);
            end
            total++;
            if (cnt != 400) begin
                bad++;
                $display("FAIL timeout_wait_pass%0d got=%0d required=400", p, cnt);
            end
        end
        total++;
        if (pkt_fail !== 1'b1 || busy !== 1'b0 || wr_ptr_dbg !== 9'd0) begin
            bad++;
            $display("FAIL retry_fail pkt_fail=%b busy=%b wr_ptr=%0d required 1 0 0",
                     pkt_fail, busy, wr_ptr_dbg);
        end
        check_caps("retry_passes");
        repeat (3) @(negedge clock);
        total++;
        if (fail_cnt != 1 || done_cnt != 0) begin
            bad++;
            $display("FAIL retry_pulses fail=%0d done=%0d required 1 0", fail_cnt, done_cnt);
        end
    endtask

    task automatic test_nak_retry();
        do_reset();
        write_three();
        exp_q = {16'hA1B2, 16'hC3D4, 16'hE5F6, 16'hA1B2, 16'hC3D4, 16'hE5F6};
        cap_q = {};
        stab_bad = 0;
        go_pkt();
        run_pass(3, 11, -1);
        repeat (2) @(negedge clock);
        send_rx(8'hBB);
        total++;
        if (retry_count !== 2'd1 || tx_if.tx_en !== 1'b1 ||
            {tx_if.tx_data2, tx_if.tx_data1} !== 16'hA1B2) begin
            bad++;
            $display("FAIL nak_restart retry=%0d tx_en=%b data=%h required 1 1 a1b2",
                     retry_count, tx_if.tx_en, {tx_if.tx_data2, tx_if.tx_data1});
        end
        run_pass(3, 11, -1);
        check_caps("nak_passes");
        send_rx(8'h11);
        total++;
        if (pkt_done !== 1'b1 || retry_count !== 2'd1) begin
            bad++;
            $display("FAIL nak_done pkt_done=%b retry=%0d required 1 1", pkt_done, retry_count);
        end
    endtask

    task automatic test_full();
        logic [15:0] w;
        do_reset();
        exp_q = {};
        cap_q = {};
        stab_bad = 0;
        for (int i = 0; i < 256; i++) begin
            w = {8'(i) ^ 8'h5A, 8'(i)};
            exp_q.push_back(w);
            if (i == 255) begin
                total++;
                if (wr_full !== 1'b0) begin
                    bad++;
                    $display("FAIL full_early got=%b required 0 after 255 writes", wr_full);
                end
            end
            write_word(w);
        end
        total++;
        if (wr_full !== 1'b1 || wr_ptr_dbg !== 9'd256) begin
            bad++;
            $display("FAIL full_256 wr_full=%b wr_ptr=%0d required 1 256", wr_full, wr_ptr_dbg);
        end
        write_word(16'hDEAD);
        total++;
        if (wr_full !== 1'b1 || wr_ptr_dbg !== 9'd256) begin
            bad++;
            $display("FAIL full_drop wr_full=%b wr_ptr=%0d required 1 256", wr_full, wr_ptr_dbg);
        end
        go_pkt();
        run_pass(256, 2, -1);
        check_caps("full_pass");
        total++;
        if (tx_if.tx_en !== 1'b0 || state_dbg !== WAIT_ACK) begin
            bad++;
            $display("FAIL full_end tx_en=%b state=%0d required 0 WAIT_ACK", tx_if.tx_en, state_dbg);
        end
        send_rx(8'h11);
    endtask

    task automatic test_empty_go();
        do_reset();
        en_cnt = 0;
        go_pkt();
        repeat (5) @(negedge clock);
        total++;
        if (busy !== 1'b0 || en_cnt != 0) begin
            bad++;
            $display("FAIL empty_go busy=%b tx_en_cycles=%0d required 0 0", busy, en_cnt);
        end
    endtask

    task automatic test_abort_reset();
        do_reset();
        write_three();
        cap_q = {};
        stab_bad = 0;
        done_cnt = 0;
        fail_cnt = 0;
        go_pkt();
        run_pass(3, 11, 1);
        total++;
        if ({busy, tx_if.tx_en, tx_if.tx_ready, pkt_done, pkt_fail} !== 5'b0 ||
            {tx_if.tx_data2, tx_if.tx_data1} !== 16'h0 || retry_count !== 2'd0 ||
            wr_ptr_dbg !== 9'd0 || state_dbg !== IDLE) begin
            bad++;
            $display("FAIL abort_idle flags=%b data=%h retry=%0d wr_ptr=%0d state=%0d required all 0",
                     {busy, tx_if.tx_en, tx_if.tx_ready, pkt_done, pkt_fail},
                     {tx_if.tx_data2, tx_if.tx_data1}, retry_count, wr_ptr_dbg, state_dbg);
        end
        write_three();
        go_pkt();
        run_pass(3, 11, -1);
        total++;
        if (state_dbg !== WAIT_ACK) begin
            bad++;
            $display("FAIL reset_setup state=%0d required WAIT_ACK", state_dbg);
        end
        reset = 1'b1;
        @(negedge clock);
        total++;
        if ({busy, tx_if.tx_en, tx_if.tx_ready, pkt_done, pkt_fail, wr_full} !== 6'b0 ||
            {tx_if.tx_data2, tx_if.tx_data1} !== 16'h0 || retry_count !== 2'd0 ||
            wr_ptr_dbg !== 9'd0 || state_dbg !== IDLE) begin
            bad++;
            $display("FAIL reset_wait_ack flags=%b data=%h retry=%0d wr_ptr=%0d state=%0d required all 0",
                     {busy, tx_if.tx_en, tx_if.tx_ready, pkt_done, pkt_fail, wr_full},
                     {tx_if.tx_data2, tx_if.tx_data1}, retry_count, wr_ptr_dbg, state_dbg);
        end
        reset = 1'b0;
        repeat (3) @(negedge clock);
        total++;
        if (done_cnt != 0 || fail_cnt != 0) begin
            bad++;
            $display("FAIL abort_pulses done=%0d fail=%0d required 0 0", done_cnt, fail_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_ack();
        test_retry_timeout();
        test_nak_retry();
        test_full();
        test_empty_go();
        test_abort_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
